// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle CPU control FSM (fetch/decode/exec/mem/wb/halt)
module multicycle_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] I_Opcode,
    input  logic       I_Zero,
    input  logic       I_MemReady,
    output logic       C_ALUSrc_A,
    output logic [2:0] C_ALUSrc_B,
    output logic       C_SignExtend,
    output logic [1:0] C_RegDstRead1R,
    output logic       C_RegDstRead2R,
    output logic       C_PCWrite,
    output logic       C_PCSrc,
    output logic       C_IRWrite,
    output logic       C_MemRead,
    output logic       C_MemWrite,
    output logic       C_RegWrite,
    output logic       C_Halted,
    output logic       C_Illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ORI  = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic       illegal_q, illegal_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opcode_q  <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (I_MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = I_Opcode;
                case (I_Opcode)
                    OP_R, OP_ADDI, OP_ORI, OP_LW,
                    OP_SW, OP_BEQ, OP_JMP: state_d = S_EXEC;
                    OP_HALT:               state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_R, OP_ADDI, OP_ORI: state_d = S_WB;
                    OP_LW, OP_SW:          state_d = S_MEM;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (I_MemReady) state_d = (opcode_q == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by rst_n so nothing strobes while reset is held.
    always_comb begin
        C_ALUSrc_A     = 1'b0;
        C_ALUSrc_B     = 3'b000;
        C_SignExtend   = 1'b0;
        C_RegDstRead1R = 2'b00;
        C_RegDstRead2R = 1'b0;
        C_PCWrite      = 1'b0;
        C_PCSrc        = 1'b0;
        C_IRWrite      = 1'b0;
        C_MemRead      = 1'b0;
        C_MemWrite     = 1'b0;
        C_RegWrite     = 1'b0;
        C_Halted       = 1'b0;
        C_Illegal      = illegal_q & rst_n;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    C_MemRead  = 1'b1;
                    C_ALUSrc_B = 3'b001;
                    C_IRWrite  = I_MemReady;
                    C_PCWrite  = I_MemReady;
                end
                S_DECODE: begin
                    C_ALUSrc_B = 3'b011;
                end
                S_EXEC: begin
                    case (opcode_q)
                        OP_R: begin
                            C_ALUSrc_A = 1'b1;
                        end
                        OP_ADDI, OP_LW: begin
                            C_ALUSrc_A   = 1'b1;
                            C_ALUSrc_B   = 3'b010;
                            C_SignExtend = 1'b1;
                        end
                        OP_ORI: begin
                            C_ALUSrc_A = 1'b1;
                            C_ALUSrc_B = 3'b010;
                        end
                        OP_SW: begin
                            C_ALUSrc_A     = 1'b1;
                            C_ALUSrc_B     = 3'b010;
                            C_SignExtend   = 1'b1;
                            C_RegDstRead2R = 1'b1;
                        end
                        OP_BEQ: begin
                            C_ALUSrc_A = 1'b1;
                            C_PCWrite  = I_Zero;
                            C_PCSrc    = 1'b1;
                        end
                        OP_JMP: begin
                            C_ALUSrc_B = 3'b100;
                            C_PCWrite  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (opcode_q == OP_LW) begin
                        C_MemRead = 1'b1;
                    end else begin
                        C_MemWrite     = 1'b1;
                        C_RegDstRead2R = 1'b1;
                    end
                end
                S_WB:    C_RegWrite = 1'b1;
                S_HALT:  C_Halted   = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - scoreboard bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] I_Opcode;
    logic       I_Zero;
    logic       I_MemReady;
    logic       C_ALUSrc_A;
    logic [2:0] C_ALUSrc_B;
    logic       C_SignExtend;
    logic [1:0] C_RegDstRead1R;
    logic       C_RegDstRead2R;
    logic       C_PCWrite;
    logic       C_PCSrc;
    logic       C_IRWrite;
    logic       C_MemRead;
    logic       C_MemWrite;
    logic       C_RegWrite;
    logic       C_Halted;
    logic       C_Illegal;

    multicycle_ctrl_fsm dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .I_Opcode       (I_Opcode),
        .I_Zero         (I_Zero),
        .I_MemReady     (I_MemReady),
        .C_ALUSrc_A     (C_ALUSrc_A),
        .C_ALUSrc_B     (C_ALUSrc_B),
        .C_SignExtend   (C_SignExtend),
        .C_RegDstRead1R (C_RegDstRead1R),
        .C_RegDstRead2R (C_RegDstRead2R),
        .C_PCWrite      (C_PCWrite),
        .C_PCSrc        (C_PCSrc),
        .C_IRWrite      (C_IRWrite),
        .C_MemRead      (C_MemRead),
        .C_MemWrite     (C_MemWrite),
        .C_RegWrite     (C_RegWrite),
        .C_Halted       (C_Halted),
        .C_Illegal      (C_Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {A, B[2:0], SE, R1[1:0], R2, PCW, PCS, IRW, MR, MW, RW, HALT, ILL}
    function automatic logic [15:0] ev(input logic a, input logic [2:0] b, input logic se,
                                       input logic [1:0] r1, input logic r2, input logic pcw,
                                       input logic pcs, input logic irw, input logic mr,
                                       input logic mw, input logic rw, input logic h,
                                       input logic il);
        return {a, b, se, r1, r2, pcw, pcs, irw, mr, mw, rw, h, il};
    endfunction

    logic [15:0] act;
    assign act = {C_ALUSrc_A, C_ALUSrc_B, C_SignExtend, C_RegDstRead1R, C_RegDstRead2R,
                  C_PCWrite, C_PCSrc, C_IRWrite, C_MemRead, C_MemWrite, C_RegWrite,
                  C_Halted, C_Illegal};

    logic [15:0] ZERO, F0, F1, DEC, E_R, E_ADDI, E_ORI, E_LW, E_SW, E_BEQ1, E_BEQ0, E_JMP;
    logic [15:0] M_LW, M_SW, WB, HLT, HLT_ILL;

    initial begin
        ZERO    = 16'h0000;
        F0      = ev(0, 3'b001, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        F1      = ev(0, 3'b001, 0, 2'b00, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        DEC     = ev(0, 3'b011, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_R     = ev(1, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_ADDI  = ev(1, 3'b010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_ORI   = ev(1, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_LW    = ev(1, 3'b010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_SW    = ev(1, 3'b010, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        E_BEQ1  = ev(1, 3'b000, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        E_BEQ0  = ev(1, 3'b000, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        E_JMP   = ev(0, 3'b100, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        M_LW    = ev(0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        M_SW    = ev(0, 3'b000, 0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        WB      = ev(0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        HLT     = ev(0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        HLT_ILL = ev(0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    end

    logic [15:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: actual=%b required=%b", n, act, e);
            end
            if (C_MemRead && C_MemWrite) begin
                failures++;
                $display("FAIL %s_mem_excl: actual MemRead=1 MemWrite=1 required not both", n);
            end
        end
    end

    task automatic step(input logic rst, input logic [3:0] op, input logic z, input logic rdy,
                        input logic [15:0] e, input string n);
        rst_n      = rst;
        I_Opcode   = op;
        I_Zero     = z;
        I_MemReady = rdy;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; I_Opcode = 4'b0000; I_Zero = 1'b0; I_MemReady = 1'b0;
        @(posedge clk);
        #1;
        step(0, 4'b0000, 0, 1, ZERO,   "reset_0");
        step(0, 4'b1111, 1, 1, ZERO,   "reset_1");
        // R-type, 4 cycles
        step(1, 4'b0000, 0, 1, F1,     "r_fetch");
        step(1, 4'b0000, 0, 1, DEC,    "r_decode");
        step(1, 4'b1010, 0, 1, E_R,    "r_exec");
        step(1, 4'b1010, 0, 1, WB,     "r_wb");
        // fetch wait then LW with 3 MEM wait cycles, 8 cycles after the wait
        step(1, 4'b0000, 0, 0, F0,     "fetch_wait");
        step(1, 4'b0000, 0, 1, F1,     "lw_fetch");
        step(1, 4'b0011, 0, 1, DEC,    "lw_decode");
        step(1, 4'b0000, 0, 0, E_LW,   "lw_exec");
        step(1, 4'b0000, 0, 0, M_LW,   "lw_mem_w1");
        step(1, 4'b0000, 0, 0, M_LW,   "lw_mem_w2");
        step(1, 4'b0000, 0, 0, M_LW,   "lw_mem_w3");
        step(1, 4'b0000, 0, 1, M_LW,   "lw_mem_done");
        step(1, 4'b0000, 0, 0, WB,     "lw_wb");
        // BEQ taken / not taken
        step(1, 4'b0000, 0, 1, F1,     "beq1_fetch");
        step(1, 4'b0101, 0, 1, DEC,    "beq1_decode");
        step(1, 4'b0000, 1, 1, E_BEQ1, "beq1_exec");
        step(1, 4'b0000, 0, 1, F1,     "beq0_fetch");
        step(1, 4'b0101, 0, 1, DEC,    "beq0_decode");
        step(1, 4'b0000, 0, 1, E_BEQ0, "beq0_exec");
        // ORI vs ADDI
        step(1, 4'b0000, 0, 1, F1,     "ori_fetch");
        step(1, 4'b0010, 0, 1, DEC,    "ori_decode");
        step(1, 4'b0000, 0, 1, E_ORI,  "ori_exec");
        step(1, 4'b0000, 0, 1, WB,     "ori_wb");
        step(1, 4'b0000, 0, 1, F1,     "addi_fetch");
        step(1, 4'b0001, 0, 1, DEC,    "addi_decode");
        step(1, 4'b0000, 0, 1, E_ADDI, "addi_exec");
        step(1, 4'b0000, 0, 1, WB,     "addi_wb");
        // JMP, 3 cycles
        step(1, 4'b0000, 0, 1, F1,     "jmp_fetch");
        step(1, 4'b0110, 0, 1, DEC,    "jmp_decode");
        step(1, 4'b0000, 1, 1, E_JMP,  "jmp_exec");
        // SW zero-wait, 4 cycles
        step(1, 4'b0000, 0, 1, F1,     "sw_fetch");
        step(1, 4'b0100, 0, 1, DEC,    "sw_decode");
        step(1, 4'b0000, 0, 1, E_SW,   "sw_exec");
        step(1, 4'b0000, 0, 1, M_SW,   "sw_mem");
        // SW with reset during the MEM wait
        step(1, 4'b0000, 0, 1, F1,     "swr_fetch");
        step(1, 4'b0100, 0, 1, DEC,    "swr_decode");
        step(1, 4'b0000, 0, 0, E_SW,   "swr_exec");
        step(1, 4'b0000, 0, 0, M_SW,   "swr_mem_wait");
        step(0, 4'b0000, 0, 1, ZERO,   "swr_reset");
        step(1, 4'b0000, 0, 0, F0,     "swr_restart");
        step(1, 4'b0000, 0, 0, F0,     "swr_restart_hold");
        // illegal opcode: sticky until reset
        step(1, 4'b0000, 0, 1, F1,     "ill_fetch");
        step(1, 4'b1010, 0, 1, DEC,    "ill_decode");
        step(1, 4'b0011, 1, 1, HLT_ILL,"ill_halt_0");
        step(1, 4'b0000, 0, 0, HLT_ILL,"ill_halt_1");
        step(1, 4'b0101, 1, 1, HLT_ILL,"ill_halt_2");
        step(0, 4'b0000, 0, 1, ZERO,   "ill_reset");
        step(1, 4'b0000, 0, 1, F1,     "ill_refetch");
        // HALT opcode: halted without illegal
        step(1, 4'b1111, 0, 1, DEC,    "halt_decode");
        step(1, 4'b0000, 0, 1, HLT,    "halt_0");
        step(1, 4'b0011, 1, 0, HLT,    "halt_1");
        step(0, 4'b0000, 0, 1, ZERO,   "halt_reset");
        step(1, 4'b0000, 0, 1, F1,     "final_fetch");
        step(1, 4'b0000, 0, 1, DEC,    "final_decode");

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
